// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Forward-select encodings, scoreboard entry layout and stall-cause codes.
package hazard_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  typedef struct packed {
    logic              valid;
    logic              reg_we;
    logic [REG_AW-1:0] wra;
    logic              is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, reg_we: 1'b0, wra: '0, is_load: 1'b0};

  typedef enum logic [1:0] {
    STALL_NONE     = 2'd0,
    STALL_LOAD_USE = 2'd1,
    STALL_MDU      = 2'd2
  } stall_cause_t;

  // $0 is hardwired, so a write to it never produces a usable value.
  function automatic logic sb_match(sb_entry_t e, logic [REG_AW-1:0] r, logic rd_en);
    return e.valid && e.reg_we && (e.wra == r) && (r != '0) && rd_en;
  endfunction

  function automatic logic [1:0] fwd_select(sb_entry_t e, sb_entry_t m, sb_entry_t w,
                                            logic [REG_AW-1:0] r, logic rd_en);
    if (sb_match(e, r, rd_en)) return FWD_E;
    if (sb_match(m, r, rd_en)) return FWD_M;
    if (sb_match(w, r, rd_en)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_timer.sv
// MDU busy timer: loads the multiply or divide latency on an accepted start,
// then counts down to zero; busy while nonzero.
import hazard_pkg::*;

module mdu_timer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= is_div ? DIV_LOAD : MUL_LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: E/M/W destination scoreboard, decode forwarding
// selects, load-use / MDU stalls and branch flush. Optional macro HAZARD_PERF_EN.
import hazard_pkg::*;

module hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_dec_valid,
  input  logic [4:0]  i_dec_ra1,
  input  logic [4:0]  i_dec_ra2,
  input  logic        i_dec_use1,
  input  logic        i_dec_use2,
  input  logic        i_dec_regWe,
  input  logic [4:0]  i_dec_wra,
  input  logic        i_dec_isLoad,
  input  logic        i_dec_mduStart,
  input  logic        i_dec_mduDiv,
  input  logic        i_dec_mduRead,
  input  logic        i_br_taken,
  output logic        o_stallF,
  output logic        o_stallD,
  output logic        o_flushD,
  output logic        o_flushE,
  output logic [1:0]  o_fwd1,
  output logic [1:0]  o_fwd2,
  output logic        o_mdu_busy,
  output logic [31:0] o_stall_cycles
);

  sb_entry_t    sb_e, sb_m, sb_w;
  sb_entry_t    dec_entry;
  stall_cause_t stall_cause;
  logic         load_use_hit;
  logic         mdu_hit;
  logic         stall;
  logic         mdu_busy;
  logic         mdu_accept;

  assign load_use_hit = i_dec_valid && sb_e.is_load &&
                        (sb_match(sb_e, i_dec_ra1, i_dec_use1) ||
                         sb_match(sb_e, i_dec_ra2, i_dec_use2));

  assign mdu_hit = i_dec_valid && (i_dec_mduStart || i_dec_mduRead) && mdu_busy;

  always_comb begin
    stall_cause = STALL_NONE;
    if (load_use_hit) begin
      stall_cause = STALL_LOAD_USE;
    end else if (mdu_hit) begin
      stall_cause = STALL_MDU;
    end
  end

  assign stall = (stall_cause != STALL_NONE);

  assign o_stallF = stall;
  assign o_stallD = stall;
  assign o_flushE = stall;
  // A stalled branch re-resolves next cycle with forwarded operands.
  assign o_flushD = i_br_taken && !stall;

  assign o_fwd1 = fwd_select(sb_e, sb_m, sb_w, i_dec_ra1, i_dec_use1);
  assign o_fwd2 = fwd_select(sb_e, sb_m, sb_w, i_dec_ra2, i_dec_use2);

  assign dec_entry = '{valid: 1'b1, reg_we: i_dec_regWe, wra: i_dec_wra,
                       is_load: i_dec_isLoad};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sb_e <= SB_BUBBLE;
      sb_m <= SB_BUBBLE;
      sb_w <= SB_BUBBLE;
    end else begin
      sb_w <= sb_m;
      sb_m <= sb_e;
      sb_e <= (i_dec_valid && !stall) ? dec_entry : SB_BUBBLE;
    end
  end

  assign mdu_accept = i_dec_valid && i_dec_mduStart && !stall;

  mdu_timer #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu_timer (
    .clk    (clk),
    .rstn   (rstn),
    .start  (mdu_accept),
    .is_div (i_dec_mduDiv),
    .busy   (mdu_busy)
  );

  assign o_mdu_busy = mdu_busy;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

  assign o_stall_cycles = stall_cycles;
`else
  assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic against an issue-history reference model.
module tb_hazard_ctrl;

  localparam int MUL_C = 4;
  localparam int DIV_C = 32;
  localparam int HN    = 8192;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        dec_valid, dec_use1, dec_use2, dec_regwe, dec_is_load;
  logic [4:0]  dec_ra1, dec_ra2, dec_wra;
  logic        mdu_start, mdu_div, mdu_read, br_taken;
  logic        stall_f, stall_d, flush_d, flush_e, mdu_busy;
  logic [1:0]  fwd1, fwd2;
  logic [31:0] stall_cycles;

  hazard_ctrl #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_dec_valid    (dec_valid),
    .i_dec_ra1      (dec_ra1),
    .i_dec_ra2      (dec_ra2),
    .i_dec_use1     (dec_use1),
    .i_dec_use2     (dec_use2),
    .i_dec_regWe    (dec_regwe),
    .i_dec_wra      (dec_wra),
    .i_dec_isLoad   (dec_is_load),
    .i_dec_mduStart (mdu_start),
    .i_dec_mduDiv   (mdu_div),
    .i_dec_mduRead  (mdu_read),
    .i_br_taken     (br_taken),
    .o_stallF       (stall_f),
    .o_stallD       (stall_d),
    .o_flushD       (flush_d),
    .o_flushE       (flush_e),
    .o_fwd1         (fwd1),
    .o_fwd2         (fwd2),
    .o_mdu_busy     (mdu_busy),
    .o_stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: what entered E on each cycle, plus the last busy cycle.
  logic       h_v  [HN];
  logic       h_we [HN];
  logic [4:0] h_wra[HN];
  logic       h_ld [HN];
  int         cyc = 4;
  int         busy_end = -1;
  int         perf = 0;

  logic        e_stall, e_flush_d, e_busy;
  logic [1:0]  e_fwd1, e_fwd2;
  logic [31:0] e_perf;

  // Producer of age a issued a cycles ago; E=1, M=2, W=3.
  function automatic logic hit(int age, logic [4:0] r, logic en);
    int t = cyc - age;
    return en && (r != 5'd0) && h_v[t] && h_we[t] && (h_wra[t] == r);
  endfunction

  function automatic logic [1:0] youngest(logic [4:0] r, logic en);
    for (int a = 1; a <= 3; a++) if (hit(a, r, en)) return 2'(a);
    return 2'd0;
  endfunction

  task automatic model_eval();
    logic lu, md;
    e_busy    = (cyc <= busy_end);
    lu        = dec_valid && h_ld[cyc-1] && (hit(1, dec_ra1, dec_use1) || hit(1, dec_ra2, dec_use2));
    md        = dec_valid && (mdu_start || mdu_read) && e_busy;
    e_stall   = lu || md;
    e_flush_d = br_taken && !e_stall;
    e_fwd1    = youngest(dec_ra1, dec_use1);
    e_fwd2    = youngest(dec_ra2, dec_use2);
`ifdef HAZARD_PERF_EN
    e_perf = 32'(perf);
`else
    e_perf = 32'd0;
`endif
  endtask

  task automatic tick();
    model_eval();
    h_v[cyc]   = dec_valid && !e_stall;
    h_we[cyc]  = dec_regwe;
    h_wra[cyc] = dec_wra;
    h_ld[cyc]  = dec_is_load;
    if (dec_valid && mdu_start && !e_stall) busy_end = cyc + (mdu_div ? DIV_C : MUL_C);
    if (e_stall) perf++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic reset_model();
    for (int a = 0; a <= 3; a++) h_v[cyc-a] = 1'b0;
    busy_end = -1;
    perf = 0;
  endtask

  task automatic set_idle();
    dec_valid = 0; dec_use1 = 0; dec_use2 = 0; dec_regwe = 0; dec_is_load = 0;
    dec_ra1 = 0; dec_ra2 = 0; dec_wra = 0;
    mdu_start = 0; mdu_div = 0; mdu_read = 0; br_taken = 0;
  endtask

  task automatic test_reset();
    set_idle();
    rstn = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1;
    reset_model();
    tick();
    settle();
    checks++; if (stall_f !== 1'b0) begin errors++; $display("FAIL reset_stallF: got %b want 0", stall_f); end
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL reset_stallD: got %b want 0", stall_d); end
    checks++; if (flush_d !== 1'b0) begin errors++; $display("FAIL reset_flushD: got %b want 0", flush_d); end
    checks++; if (flush_e !== 1'b0) begin errors++; $display("FAIL reset_flushE: got %b want 0", flush_e); end
    checks++; if (fwd1 !== 2'd0) begin errors++; $display("FAIL reset_fwd1: got %0d want 0", fwd1); end
    checks++; if (fwd2 !== 2'd0) begin errors++; $display("FAIL reset_fwd2: got %0d want 0", fwd2); end
    checks++; if (mdu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", mdu_busy); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_perf: got %0d want 0", stall_cycles); end
    tick();
  endtask

  task automatic test_forward_chain();
    set_idle(); dec_valid = 1; dec_regwe = 1; dec_wra = 5'd3;
    tick();
    set_idle(); dec_valid = 1; dec_ra1 = 5'd3; dec_use1 = 1; dec_wra = 5'd9;
    settle();
    checks++; if (fwd1 !== 2'd1) begin errors++; $display("FAIL fwd_from_e: got %0d want 1", fwd1); end
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL fwd_no_stall: got %b want 0", stall_d); end
    checks++; if (fwd2 !== 2'd0) begin errors++; $display("FAIL fwd2_unused: got %0d want 0", fwd2); end
    tick(); settle();
    checks++; if (fwd1 !== 2'd2) begin errors++; $display("FAIL fwd_from_m: got %0d want 2", fwd1); end
    tick(); settle();
    checks++; if (fwd1 !== 2'd3) begin errors++; $display("FAIL fwd_from_w: got %0d want 3", fwd1); end
    tick(); settle();
    checks++; if (fwd1 !== 2'd0) begin errors++; $display("FAIL fwd_retired: got %0d want 0", fwd1); end
    tick();
  endtask

  task automatic test_load_use();
    set_idle(); dec_valid = 1; dec_regwe = 1; dec_wra = 5'd5; dec_is_load = 1;
    tick();
    set_idle(); dec_valid = 1; dec_ra2 = 5'd5; dec_use2 = 1; dec_regwe = 1; dec_wra = 5'd6;
    settle();
    checks++; if ({stall_f, stall_d, flush_e} !== 3'b111) begin errors++; $display("FAIL lu_stall: got %b want 111", {stall_f, stall_d, flush_e}); end
    checks++; if (flush_d !== 1'b0) begin errors++; $display("FAIL lu_flushD: got %b want 0", flush_d); end
    tick(); settle();
    checks++; if ({stall_f, stall_d, flush_e} !== 3'b000) begin errors++; $display("FAIL lu_release: got %b want 000", {stall_f, stall_d, flush_e}); end
    checks++; if (fwd2 !== 2'd2) begin errors++; $display("FAIL lu_fwd_m: got %0d want 2", fwd2); end
    tick();
  endtask

  task automatic test_zero_reg();
    set_idle(); dec_valid = 1; dec_regwe = 1; dec_wra = 5'd0; dec_is_load = 1;
    tick();
    set_idle(); dec_valid = 1; dec_use1 = 1; dec_use2 = 1;
    settle();
    checks++; if (fwd1 !== 2'd0) begin errors++; $display("FAIL r0_fwd1: got %0d want 0", fwd1); end
    checks++; if (fwd2 !== 2'd0) begin errors++; $display("FAIL r0_fwd2: got %0d want 0", fwd2); end
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL r0_stall: got %b want 0", stall_d); end
    tick();
  endtask

  task automatic test_mdu();
    int n;
    logic [31:0] perf_base;
    set_idle();
    repeat (DIV_C + 2) tick();
    settle();
    perf_base = e_perf;
    set_idle(); dec_valid = 1; mdu_start = 1; mdu_div = 1;
    tick();
    set_idle(); dec_valid = 1;
    settle();
    checks++; if (mdu_busy !== 1'b1) begin errors++; $display("FAIL div_busy: got %b want 1", mdu_busy); end
    tick();
    set_idle(); dec_valid = 1; mdu_read = 1; dec_regwe = 1; dec_wra = 5'd8;
    n = 0;
    settle();
    while (stall_d === 1'b1 && n < 100) begin
      checks++; if (mdu_busy !== 1'b1) begin errors++; $display("FAIL mdu_stall_busy: got %b want 1 at stall %0d", mdu_busy, n); end
      tick(); settle();
      n++;
    end
    checks++; if (n != 31) begin errors++; $display("FAIL mflo_stall_len: got %0d want 31", n); end
    checks++; if (mdu_busy !== 1'b0) begin errors++; $display("FAIL div_idle: got %b want 0", mdu_busy); end
`ifdef HAZARD_PERF_EN
    checks++; if (stall_cycles !== perf_base + 32'd31) begin errors++; $display("FAIL perf_div: got %0d want %0d", stall_cycles, perf_base + 32'd31); end
`else
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL perf_off: got %0d want 0 (base %0d)", stall_cycles, perf_base); end
`endif
    tick();
    set_idle(); dec_valid = 1; mdu_start = 1; mdu_div = 0;
    tick();
    set_idle();
    n = 0;
    settle();
    while (mdu_busy === 1'b1 && n < 50) begin
      tick(); settle();
      n++;
    end
    checks++; if (n != MUL_C) begin errors++; $display("FAIL mul_busy_len: got %0d want %0d", n, MUL_C); end
    tick();
  endtask

  task automatic test_branch();
    set_idle(); dec_valid = 1; dec_regwe = 1; dec_wra = 5'd7; dec_is_load = 1;
    tick();
    set_idle(); dec_valid = 1; dec_ra1 = 5'd7; dec_use1 = 1; br_taken = 1;
    settle();
    checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL br_stall: got %b want 1", stall_d); end
    checks++; if (flush_d !== 1'b0) begin errors++; $display("FAIL br_stall_wins: got %b want 0", flush_d); end
    tick(); settle();
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL br_nostall: got %b want 0", stall_d); end
    checks++; if (flush_d !== 1'b1) begin errors++; $display("FAIL br_flush: got %b want 1", flush_d); end
    tick();
    set_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      dec_valid   = ($urandom_range(0, 9) != 0);
      dec_ra1     = 5'($urandom_range(0, 3));
      dec_ra2     = 5'($urandom_range(0, 3));
      dec_use1    = 1'($urandom_range(0, 1));
      dec_use2    = 1'($urandom_range(0, 1));
      dec_regwe   = ($urandom_range(0, 3) != 0);
      dec_wra     = 5'($urandom_range(0, 3));
      dec_is_load = ($urandom_range(0, 3) == 0);
      mdu_start   = ($urandom_range(0, 19) == 0);
      mdu_div     = ($urandom_range(0, 3) == 0);
      mdu_read    = ($urandom_range(0, 9) == 0);
      br_taken    = ($urandom_range(0, 3) == 0);
      settle();
      checks++;
      if ({stall_f, stall_d, flush_e} !== {3{e_stall}} || flush_d !== e_flush_d ||
          fwd1 !== e_fwd1 || fwd2 !== e_fwd2 || mdu_busy !== e_busy || stall_cycles !== e_perf) begin
        errors++;
        if (errors < 20)
          $display("FAIL rand_%0d: got stall=%b%b%b flushD=%b fwd=%0d/%0d busy=%b perf=%0d want stall=%b flushD=%b fwd=%0d/%0d busy=%b perf=%0d",
                   i, stall_f, stall_d, flush_e, flush_d, fwd1, fwd2, mdu_busy, stall_cycles,
                   e_stall, e_flush_d, e_fwd1, e_fwd2, e_busy, e_perf);
      end
      tick();
    end
    set_idle();
  endtask

  task automatic test_reset_mid_div();
    set_idle();
    repeat (DIV_C + 2) tick();
    set_idle(); dec_valid = 1; mdu_start = 1; mdu_div = 1;
    tick();
    set_idle();
    tick(); tick();
    settle();
    checks++; if (mdu_busy !== 1'b1) begin errors++; $display("FAIL middiv_busy: got %b want 1", mdu_busy); end
    #2 rstn = 0;
    #1;
    checks++; if (mdu_busy !== 1'b0) begin errors++; $display("FAIL async_busy_drop: got %b want 0", mdu_busy); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL async_perf_clear: got %0d want 0", stall_cycles); end
    @(negedge clk);
    rstn = 1;
    reset_model();
    tick(); settle();
    checks++; if (mdu_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", mdu_busy); end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < HN; i++) begin
      h_v[i] = 1'b0; h_we[i] = 1'b0; h_wra[i] = 5'd0; h_ld[i] = 1'b0;
    end
    set_idle();
    test_reset();
    test_forward_chain();
    test_load_use();
    test_zero_reg();
    test_mdu();
    test_branch();
    test_random();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage MIPS core (F/D/E/M/W). Keeps a shadow scoreboard of in-flight destination registers in E, M and W, and uses it to produce forwarding selects for the decode-stage read ports. Also generates stall and flush signals for load-use hazards, branches and the multi-cycle multiply/divide unit (MDU), and owns the MDU busy timer.

Parameters:
MUL_CYCLES, 4, cycles MDU stays busy after a multiply start (>=1)
DIV_CYCLES, 32, cycles MDU stays busy after a divide start (>=1)

Ports:
clk  in  1  clock
rstn  in  1  reset
i_dec_valid  in  1  decode stage holds a real instruction
i_dec_ra1  in  5  decode source register 1 (rs)
i_dec_ra2  in  5  decode source register 2 (rt)
i_dec_use1  in  1  instruction reads ra1
i_dec_use2  in  1  instruction reads ra2
i_dec_regWe  in  1  instruction writes the register file
i_dec_wra  in  5  destination register, already muxed rt/rd
i_dec_isLoad  in  1  instruction is a load
i_dec_mduStart  in  1  mult/div issue
i_dec_mduDiv  in  1  1 = divide, 0 = multiply; valid with mduStart
i_dec_mduRead  in  1  mfhi/mflo
i_br_taken  in  1  BranchUnit redirect this cycle
o_stallF  out  1  hold PC
o_stallD  out  1  hold F/D register
o_flushD  out  1  clear F/D register
o_flushE  out  1  insert bubble into D/E register
o_fwd1  out  2  forward select for read port 1
o_fwd2  out  2  forward select for read port 2
o_mdu_busy  out  1  MDU timer running
o_stall_cycles  out  32  performance counter (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-low on rstn; clock is clk.
- Reset state: scoreboard entries E/M/W all invalid, MDU counter 0, o_stall_cycles 0.
- All outputs are combinational from state and inputs. After reset they are: stall/flush 0, fwd 0, busy 0.
- Scoreboard: each stage holds {valid, regWe, wra, isLoad}. Every posedge: W<=M, M<=E.
  - E <= decode fields when i_dec_valid and no stall and no flush.
  - Otherwise E <= invalid (bubble).
- Match rule: a stage matches src r when the stage is valid, regWe=1, wra==r, r!=0, and the matching use bit is set.
- Forward select per port, priority E > M > W:
  - E match -> 1
  - M match -> 2
  - W match -> 3
  - none -> 0 (register-file value)
  - A load in M selects 2; the datapath mux picks dMemRDataM for that case.
- Load-use stall: E entry is a load and matches a used source.
  - Asserts o_stallF = o_stallD = o_flushE = 1 for exactly one cycle.
  - Next cycle the load is in M and forwarding select 2 resolves the hazard.
- MDU timer:
  - On an mduStart that is accepted (no stall), load the counter with DIV_CYCLES or MUL_CYCLES.
  - Decrement each cycle while nonzero.
  - o_mdu_busy = (counter != 0).
- MDU stall: i_dec_valid and (mduStart or mduRead) while busy.
  - Same stall/bubble triple as load-use.
  - Held until the cycle after the counter reaches 0.
- Branch: o_flushD = i_br_taken and not o_stallD.
  - If a stall and a branch coincide, the stall wins; the branch re-evaluates next cycle with forwarded operands.
- Invalid decode (i_dec_valid=0): no stall is raised; the instruction enters E as a bubble.
- Register 0: never forwarded and never stalls.
- Reset asserted mid-division clears the counter immediately; busy drops asynchronously.

Optional Feature:
HAZARD_PERF_EN
- Defined: o_stall_cycles increments each cycle o_stallD=1, saturating at 0xFFFFFFFF.
- Undefined: counter logic is absent and o_stall_cycles is tied to 0.

Decomposition:
- Shared package hazard_pkg:
  - forward encodings FWD_RF=2'd0, FWD_E=2'd1, FWD_M=2'd2, FWD_W=2'd3
  - scoreboard entry struct/width constants
  - stall-cause codes (NONE, LOAD_USE, MDU)
- Sub-module mdu_timer: counter, load/decrement logic and busy output, parameterised by MUL_CYCLES and DIV_CYCLES.

Test Plan:
- Reset released, no instructions -> all stall/flush 0, fwd1=fwd2=0, busy 0.
- addu $3 writing, followed next cycle by decode reading ra1=3 -> fwd1=1. One cycle later (bubble-free) -> fwd1=2. Then -> fwd1=3.
- lw $5 in E with decode reading ra2=5, use2=1 -> one cycle of stallF/stallD/flushE=1. Next cycle fwd2=2 and no stall.
- Dependence on $0 (writer wra=0) -> fwd=0 and no stall.
- div issued, mflo two cycles later -> busy for 32 cycles; stall held until the cycle after the counter reaches 0. With HAZARD_PERF_EN, o_stall_cycles increases by the stall count (31).
- br_taken coinciding with a load-use stall -> flushD=0 that cycle. br_taken asserted next cycle with no stall -> flushD=1.
